// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-master device I/O bus arbiter:
// default bus widths, default wait-state count and the sequencer states.
package io_bus_arbiter_pkg;

    localparam int IO_BUS_WIDTH_ADDR  = 32;
    localparam int IO_BUS_WIDTH_DATA  = 32;
    localparam int IO_BUS_WIDTH_CTRL  = 3;
    localparam int IO_BUS_WAIT_CYCLES = 1;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int CNT_W       = 4;
    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Combinational two-way request picker. With both masters requesting the
// winner is the master that did not win last time, unless fixed priority
// is selected, in which case master 0 always wins the tie.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       winner
);

    // Pick the winner; with no request the output is a don't-care held at 0.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = fixed ? 1'b0 : ~last;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and transaction sequencer for the device I/O bus.
// Each grant becomes one bus access of WAIT_CYCLES+1 cycles followed by a
// single-cycle acknowledge (with registered read data) to the owning master.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = IO_BUS_WIDTH_ADDR,
    parameter int DATA_W      = IO_BUS_WIDTH_DATA,
    parameter int CTRL_W      = IO_BUS_WIDTH_CTRL,
    parameter int WAIT_CYCLES = IO_BUS_WAIT_CYCLES,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CTRL_W-1:0] m1_ctrl,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [CTRL_W-1:0] bus_ctrl,
    output logic [DATA_W-1:0] bus_wd,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rd,

    output logic              owner
);

    localparam logic FIXED_BIT = (FIXED_PRIO != 0);

    // Master request fields gathered into arrays indexed by master number.
    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] we_vec;
    logic [ADDR_W-1:0]      addr_arr [NUM_MASTERS];
    logic [CTRL_W-1:0]      ctrl_arr [NUM_MASTERS];
    logic [DATA_W-1:0]      wd_arr   [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] ack_vec;
    logic [DATA_W-1:0]      rd_arr   [NUM_MASTERS];

    assign req_vec     = {m1_req, m0_req};
    assign we_vec      = {m1_we, m0_we};
    assign addr_arr[0] = m0_addr;
    assign addr_arr[1] = m1_addr;
    assign ctrl_arr[0] = m0_ctrl;
    assign ctrl_arr[1] = m1_ctrl;
    assign wd_arr[0]   = m0_wd;
    assign wd_arr[1]   = m1_wd;

    bus_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              sel_reg, sel_next;
    logic              owner_reg, owner_next;
    logic [DATA_W-1:0] rd_reg, rd_next;
    logic              winner;
    logic              in_access;
    logic              last_access;

    rr_arbiter2 u_pick (
        .req    (req_vec),
        .last   (owner_reg),
        .fixed  (FIXED_BIT),
        .winner (winner)
    );

    // State, counter, selection and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sel_reg   <= 1'b0;
            owner_reg <= 1'b1;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            owner_reg <= owner_next;
            rd_reg    <= rd_next;
        end
    end

    // Next-state logic: grant in IDLE, count wait states in ACCESS,
    // capture read data on the last ACCESS cycle, ack for one cycle in DONE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        owner_next = owner_reg;
        rd_next    = rd_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    sel_next   = winner;
                    owner_next = winner;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    rd_next    = bus_rd;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_access   = (state_reg == ST_ACCESS);
    assign last_access = in_access && (cnt_reg == '0);

    // Bus drive: selected master's fields during ACCESS, zero otherwise.
    // The write strobe fires once, on the final ACCESS cycle, and never
    // while reset is asserted.
    always_comb begin
        bus_addr = '0;
        bus_ctrl = '0;
        bus_wd   = '0;
        if (in_access) begin
            bus_addr = addr_arr[sel_reg];
            bus_ctrl = ctrl_arr[sel_reg];
            bus_wd   = wd_arr[sel_reg];
        end
    end

    assign bus_we = last_access && we_vec[sel_reg] && !rst;

    // Per-master acknowledge and read data, live only in the DONE cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign ack_vec[gi] = (state_reg == ST_DONE) && (sel_reg == 1'(gi)) && !rst;
            assign rd_arr[gi]  = ack_vec[gi] ? rd_reg : '0;
        end
    endgenerate

    assign m0_ack = ack_vec[0];
    assign m1_ack = ack_vec[1];
    assign m0_rd  = rd_arr[0];
    assign m1_rd  = rd_arr[1];
    assign owner  = owner_reg;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter. Three instances share the master/bus inputs:
// 0 = round-robin, 1 wait state; 1 = fixed priority, 1 wait state;
// 2 = round-robin, 0 wait states. Each scenario resets everything and then
// checks only the instance it targets against a transaction-level model.
module tb_io_bus_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, bus_rd;
    logic [2:0]  m0_ctrl, m1_ctrl;

    logic        ack0 [NI];
    logic        ack1 [NI];
    logic        bwe  [NI];
    logic        own  [NI];
    logic [31:0] rd0  [NI];
    logic [31:0] rd1  [NI];
    logic [31:0] baddr[NI];
    logic [31:0] bwd  [NI];
    logic [2:0]  bctrl[NI];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            io_bus_arbiter #(
                .ADDR_W      (32),
                .DATA_W      (32),
                .CTRL_W      (3),
                .WAIT_CYCLES ((gi == 2) ? 0 : 1),
                .FIXED_PRIO  ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .m0_req   (m0_req),
                .m0_addr  (m0_addr),
                .m0_ctrl  (m0_ctrl),
                .m0_we    (m0_we),
                .m0_wd    (m0_wd),
                .m0_ack   (ack0[gi]),
                .m0_rd    (rd0[gi]),
                .m1_req   (m1_req),
                .m1_addr  (m1_addr),
                .m1_ctrl  (m1_ctrl),
                .m1_we    (m1_we),
                .m1_wd    (m1_wd),
                .m1_ack   (ack1[gi]),
                .m1_rd    (rd1[gi]),
                .bus_addr (baddr[gi]),
                .bus_ctrl (bctrl[gi]),
                .bus_wd   (bwd[gi]),
                .bus_we   (bwe[gi]),
                .bus_rd   (bus_rd),
                .owner    (own[gi])
            );
        end
    endgenerate

    int checks = 0;
    int passes = 0;

    // Model state: last granted master, and the fields each master presents.
    bit          model_owner;
    logic [31:0] f_addr[2];
    logic [31:0] f_wd[2];
    logic [2:0]  f_ctrl[2];
    bit          f_we[2];

    // Directed-field overrides used by the fixed-value scenarios.
    bit          dir_en = 1'b0;
    bit          force_read = 1'b0;
    logic [31:0] dir_addr, dir_wd, dir_rd;
    logic [2:0]  dir_ctrl;
    bit          dir_we;

    task automatic drive_master(input int m);
        if (m == 0) begin
            m0_addr = f_addr[0]; m0_wd = f_wd[0]; m0_ctrl = f_ctrl[0]; m0_we = f_we[0];
        end else begin
            m1_addr = f_addr[1]; m1_wd = f_wd[1]; m1_ctrl = f_ctrl[1]; m1_we = f_we[1];
        end
    endtask

    task automatic load_master(input int m);
        if (dir_en) begin
            f_addr[m] = dir_addr; f_wd[m] = dir_wd; f_ctrl[m] = dir_ctrl; f_we[m] = dir_we;
        end else begin
            f_addr[m] = $urandom;
            f_wd[m]   = $urandom;
            f_ctrl[m] = 3'($urandom_range(0, 7));
            f_we[m]   = force_read ? 1'b0 : ($urandom_range(0, 1) == 1);
        end
        drive_master(m);
    endtask

    task automatic set_req(input int m, input bit v);
        if (m == 0) m0_req = v; else m1_req = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wd = 0; m1_wd = 0; m0_ctrl = 0; m1_ctrl = 0;
        bus_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_owner = 1'b1;
    endtask

    // Runs n grants on instance k. mask says which masters may request;
    // master 0 stops requesting after m0_grants acks. A master that is
    // waiting keeps its request and fields until it is served.
    task automatic run_sequence(input int k, input int w, input bit fixed, input int n,
                                input bit rnd, input bit [1:0] mask, input int m0_grants);
        bit          pend[2];
        bit          want;
        int          served0;
        int          last_ack;
        int          win;
        int          fb;
        logic [31:0] brd;
        logic        a_w, a_o;
        logic [31:0] r_w, r_o;
        pend[0] = 0; pend[1] = 0;
        served0 = 0; last_ack = -1; brd = '0;
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    want = mask[m] && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
                    if (m == 0 && served0 >= m0_grants) want = 1'b0;
                    if (want) load_master(m);
                    pend[m] = want;
                    set_req(m, want);
                end
            end
            if (!pend[0] && !pend[1]) begin
                fb = (mask[1]) ? 1 : 0;
                load_master(fb);
                pend[fb] = 1'b1;
                set_req(fb, 1'b1);
            end
            if (pend[0] && pend[1]) win = fixed ? 0 : (model_owner ? 0 : 1);
            else                    win = pend[0] ? 0 : 1;

            if (i > 0) begin
                @(posedge clk); #1;
                checks++; if (ack0[k] !== 1'b0 || ack1[k] !== 1'b0) $display("FAIL idle_ack inst=%0d got=%b%b exp=00", k, ack1[k], ack0[k]); else passes++;
                checks++; if (baddr[k] !== 32'h0 || bwe[k] !== 1'b0) $display("FAIL idle_bus inst=%0d got addr=%h we=%b exp 0", k, baddr[k], bwe[k]); else passes++;
            end

            for (int r = 1; r <= w + 2; r++) begin
                @(posedge clk); #1;
                if (r <= w + 1) begin
                    checks++; if (baddr[k] !== f_addr[win]) $display("FAIL bus_addr inst=%0d got=%h exp=%h", k, baddr[k], f_addr[win]); else passes++;
                    checks++; if (bctrl[k] !== f_ctrl[win]) $display("FAIL bus_ctrl inst=%0d got=%h exp=%h", k, bctrl[k], f_ctrl[win]); else passes++;
                    checks++; if (bwd[k] !== f_wd[win]) $display("FAIL bus_wd inst=%0d got=%h exp=%h", k, bwd[k], f_wd[win]); else passes++;
                    checks++; if (bwe[k] !== (f_we[win] && r == w + 1)) $display("FAIL bus_we inst=%0d cyc=%0d got=%b exp=%b", k, r, bwe[k], (f_we[win] && r == w + 1)); else passes++;
                    checks++; if (ack0[k] !== 1'b0 || ack1[k] !== 1'b0 || rd0[k] !== 32'h0 || rd1[k] !== 32'h0)
                        $display("FAIL early_ack inst=%0d got ack=%b%b rd0=%h rd1=%h exp 0", k, ack1[k], ack0[k], rd0[k], rd1[k]); else passes++;
                    brd = dir_en ? dir_rd : $urandom;
                    bus_rd = brd;
                end else begin
                    a_w = (win == 0) ? ack0[k] : ack1[k];
                    a_o = (win == 0) ? ack1[k] : ack0[k];
                    r_w = (win == 0) ? rd0[k] : rd1[k];
                    r_o = (win == 0) ? rd1[k] : rd0[k];
                    checks++; if (a_w !== 1'b1) $display("FAIL ack inst=%0d master=%0d got=%b exp=1", k, win, a_w); else passes++;
                    checks++; if (a_o !== 1'b0) $display("FAIL other_ack inst=%0d master=%0d got=%b exp=0", k, 1 - win, a_o); else passes++;
                    checks++; if (r_w !== brd) $display("FAIL rd inst=%0d master=%0d got=%h exp=%h", k, win, r_w, brd); else passes++;
                    checks++; if (r_o !== 32'h0) $display("FAIL other_rd inst=%0d got=%h exp=0", k, r_o); else passes++;
                    checks++; if (baddr[k] !== 32'h0 || bwe[k] !== 1'b0) $display("FAIL done_bus inst=%0d got addr=%h we=%b exp 0", k, baddr[k], bwe[k]); else passes++;
                    checks++; if (own[k] !== 1'(win)) $display("FAIL owner inst=%0d got=%b exp=%0d", k, own[k], win); else passes++;
                    if (last_ack >= 0) begin
                        checks++; if (cyc - last_ack !== w + 3) $display("FAIL ack_spacing inst=%0d got=%0d exp=%0d", k, cyc - last_ack, w + 3); else passes++;
                    end
                    last_ack = cyc;
                    $display("txn inst=%0d grant=%0d master=%0d we=%0d addr=%h wd=%h rd=%h", k, i, win, f_we[win], f_addr[win], f_wd[win], r_w);
                end
            end
            model_owner = (win == 1);
            pend[win] = 1'b0;
            set_req(win, 1'b0);
            if (win == 0) served0++;
        end
        m0_req = 0; m1_req = 0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (ack0[k] !== 1'b0 || ack1[k] !== 1'b0 || baddr[k] !== 32'h0)
                $display("FAIL tail_idle inst=%0d got ack=%b%b addr=%h exp 0", k, ack1[k], ack0[k], baddr[k]); else passes++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < NI; k++) begin
            checks++; if (ack0[k] !== 1'b0 || ack1[k] !== 1'b0) $display("FAIL rst_ack inst=%0d got=%b%b exp=00", k, ack1[k], ack0[k]); else passes++;
            checks++; if (rd0[k] !== 32'h0 || rd1[k] !== 32'h0) $display("FAIL rst_rd inst=%0d got=%h/%h exp=0", k, rd0[k], rd1[k]); else passes++;
            checks++; if (baddr[k] !== 32'h0 || bwd[k] !== 32'h0 || bctrl[k] !== 3'h0) $display("FAIL rst_bus inst=%0d got=%h/%h/%h exp=0", k, baddr[k], bwd[k], bctrl[k]); else passes++;
            checks++; if (bwe[k] !== 1'b0) $display("FAIL rst_we inst=%0d got=%b exp=0", k, bwe[k]); else passes++;
            checks++; if (own[k] !== 1'b1) $display("FAIL rst_owner inst=%0d got=%b exp=1", k, own[k]); else passes++;
        end
    endtask

    task automatic test_single_read();
        do_reset();
        dir_en = 1; dir_addr = 32'hFFFF_F070; dir_wd = 32'h0; dir_ctrl = 3'b010; dir_we = 0; dir_rd = 32'h0000_00A5;
        run_sequence(0, 1, 1'b0, 1, 1'b0, 2'b01, 99);
        dir_en = 0;
    endtask

    task automatic test_single_write();
        do_reset();
        dir_en = 1; dir_addr = 32'hFFFF_F060; dir_wd = 32'h1234_5678; dir_ctrl = 3'b010; dir_we = 1; dir_rd = 32'h0BAD_F00D;
        run_sequence(0, 1, 1'b0, 1, 1'b0, 2'b10, 99);
        dir_en = 0;
    endtask

    task automatic test_round_robin();
        do_reset();
        run_sequence(0, 1, 1'b0, 4, 1'b0, 2'b11, 99);
        run_sequence(0, 1, 1'b0, 12, 1'b1, 2'b11, 99);
    endtask

    task automatic test_fixed_prio();
        do_reset();
        run_sequence(1, 1, 1'b1, 5, 1'b0, 2'b11, 3);
        run_sequence(1, 1, 1'b1, 10, 1'b1, 2'b11, 99);
    endtask

    task automatic test_back_to_back();
        do_reset();
        force_read = 1;
        run_sequence(2, 0, 1'b0, 3, 1'b0, 2'b01, 99);
        force_read = 0;
        run_sequence(2, 0, 1'b0, 12, 1'b1, 2'b11, 99);
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        f_addr[0] = 32'hFFFF_F060; f_wd[0] = $urandom; f_ctrl[0] = 3'b010; f_we[0] = 1;
        drive_master(0);
        m0_req = 1;
        @(posedge clk); #1;
        checks++; if (bwe[0] !== 1'b0) $display("FAIL mid_we_first got=%b exp=0", bwe[0]); else passes++;
        @(posedge clk); #1;
        checks++; if (bwe[0] !== 1'b1 || bwd[0] !== f_wd[0]) $display("FAIL mid_we_last got we=%b wd=%h exp we=1 wd=%h", bwe[0], bwd[0], f_wd[0]); else passes++;
        rst = 1; #1;
        checks++; if (bwe[0] !== 1'b0) $display("FAIL rst_gates_we got=%b exp=0", bwe[0]); else passes++;
        m0_req = 0;
        @(posedge clk); #1;
        rst = 0;
        checks++; if (ack0[0] !== 1'b0 || baddr[0] !== 32'h0) $display("FAIL mid_rst_idle got ack=%b addr=%h exp 0", ack0[0], baddr[0]); else passes++;
        checks++; if (own[0] !== 1'b1) $display("FAIL mid_rst_owner got=%b exp=1", own[0]); else passes++;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (ack0[0] !== 1'b0 || bwe[0] !== 1'b0) $display("FAIL mid_rst_quiet got ack=%b we=%b exp 0", ack0[0], bwe[0]); else passes++;
        end
        $display("txn inst=0 reset during final write cycle addr=%h", f_addr[0]);
        model_owner = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_fixed_prio();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter and transaction sequencer for the single device I/O bus. It shares the bus (switch, LED and 7-segment devices) between the CPU data port (master 0) and the debug/program loader (master 1). Each granted request becomes exactly one bus access with a fixed number of wait states, followed by a one-cycle acknowledge to the owning master. It sits between `mini_rv`'s `mem_*` port, the loader, and `BUS`, and replaces the direct CPU-to-bus tie.

## Interface
Parameters:
- `ADDR_W`, 32, bus address width (`IO_BUS_WIDTH_ADDR`)
- `DATA_W`, 32, bus data width (`IO_BUS_WIDTH_DATA`)
- `CTRL_W`, 3, access-size/sign control width (`IO_BUS_WIDTH_CTRL`)
- `WAIT_CYCLES`, 1, device wait states per access, 0..15
- `FIXED_PRIO`, 0; 1 means master 0 always wins, 0 means round-robin

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `m0_req` in 1: master 0 access request. Held high until `m0_ack`.
- `m0_addr` in `ADDR_W`, `m0_ctrl` in `CTRL_W`, `m0_we` in 1, `m0_wd` in `DATA_W`: master 0 request fields. Held stable while `m0_req` is high.
- `m0_ack` out 1: one-cycle completion pulse for master 0.
- `m0_rd` out `DATA_W`: read data for master 0, valid while `m0_ack` is high.
- `m1_*`: same set of ports for master 1.
- `bus_addr` out `ADDR_W`, `bus_ctrl` out `CTRL_W`, `bus_wd` out `DATA_W`: request fields driven to the bus.
- `bus_we` out 1: device write strobe.
- `bus_rd` in `DATA_W`: device read data.
- `owner` out 1: index of the current or last granted master.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any `mX_req` is high, pick a winner, latch `sel`, load `cnt` with `WAIT_CYCLES`, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - `bus_addr`/`bus_ctrl`/`bus_wd` are muxed from the selected master's inputs.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, capture `bus_rd` into the `rd` register and go to DONE.
- DONE:
  - `m[sel]_ack = 1` and `m[sel]_rd = rd` for exactly one cycle, then go to IDLE.
- `bus_we` is high only in the final ACCESS cycle (`cnt == 0`) with `m[sel]_we = 1`, and is gated by `~rst`. This gives exactly one device write edge per write access.
- Arbitration:
  - Round-robin: if both masters request, the master other than `owner` wins. If only one requests, it wins.
  - `owner` updates on grant.
  - `FIXED_PRIO=1`: master 0 always wins a tie.
- Outside ACCESS, the bus outputs are 0.
- `mX_rd` is 0 except during that master's ack cycle.
- The non-selected master's ack is always 0.
- A request dropped before ack is a protocol violation. The started access still completes and still acks, and no abort happens.
- A request held high after ack is treated as a new request in the following IDLE cycle.

## Timing
- Reset values: state=IDLE, `owner`=1 (so master 0 wins the first tie), `cnt`=0, `rd`=0, all acks 0, all bus outputs 0.
- Latency: with `mX_req` first high at cycle t (in IDLE), the bus is driven from t+1 through t+1+`WAIT_CYCLES`. Ack is at t+2+`WAIT_CYCLES`.
- Throughput: back-to-back accesses take `WAIT_CYCLES`+3 cycles each.
- `WAIT_CYCLES=0`: ACCESS lasts one cycle. The write strobe and read capture happen in that cycle.
- A request arriving during ACCESS or DONE waits for IDLE. Nothing is lost.
- Reset mid-operation (rst=1 in any state):
  - No write occurs in that cycle.
  - No ack is issued.
  - The next state is IDLE with reset values.
- `rd` is registered, so read data never passes combinationally from `bus_rd` to `mX_rd`.

## Structure
- The shared header `param.v` gains:
  - the state encodings;
  - a `IO_BUS_WAIT_CYCLES` default;
  - the existing `IO_BUS_WIDTH_*` macros, which serve as parameter defaults.
- One sub-module, `rr_arbiter2`: combinational 2-way picker with inputs `req[1:0]`, `last`, `fixed` and output `winner`. Its selection logic is unit-tested separately.
- The FSM, counter, muxes and `rd` register live in `io_bus_arbiter`.

## Test plan
- Single read: m0 reads addr 0xFFFFF070 with `bus_rd`=0x0000_00A5 and `WAIT_CYCLES`=1. Required: bus driven for 2 cycles, `m0_ack` 3 cycles after req, `m0_rd`=0xA5, `bus_we` never high.
- Single write: m1 writes 0x1234_5678 to 0xFFFFF060. Required: `bus_we` high for exactly one cycle with `bus_wd`=0x12345678, then `m1_ack`, with `m0_ack` held 0.
- Simultaneous requests, round-robin: both masters hold req. Required: grant order m0, m1, m0, m1; each ack spaced 4 cycles apart with `WAIT_CYCLES`=1.
- `FIXED_PRIO=1` with both masters requesting continuously. Required: m0 acked every 4 cycles and m1 never granted; once m0 drops, m1 is granted next.
- Reset during ACCESS of a write: assert rst in the final ACCESS cycle. Required: `bus_we`=0 in that cycle, no ack, IDLE afterwards, `owner`=1.
- `WAIT_CYCLES=0`, back-to-back m0 reads of 3 addresses. Required: acks 3 cycles apart and each `m0_rd` matches the `bus_rd` presented in its single ACCESS cycle.
